// File: rtl/hazard_unit.sv
// hazard_unit: tracks in-flight destinations after decode and raises load-use/RAW stalls.
// Optional macro HAZARD_FWD_EN enables operand forwarding; the default build stalls on any RAW match.
module hazard_unit #(
  parameter int NUM_STAGES = 3,
  parameter int REG_AW     = 5,
  parameter int CNT_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              d_valid_i,
  input  logic [REG_AW-1:0] d_rs1_addr_i,
  input  logic [REG_AW-1:0] d_rs2_addr_i,
  input  logic              d_rs1_used_i,
  input  logic              d_rs2_used_i,
  input  logic [REG_AW-1:0] d_rd_addr_i,
  input  logic              d_rd_we_i,
  input  logic              d_is_load_i,
  input  logic              flush_i,
  input  logic              ext_stall_i,
  output logic              stall_o,
  output logic              incr_pc_o,
  output logic [2:0]        fwd1_sel_o,
  output logic [2:0]        fwd2_sel_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam int WIN = NUM_STAGES - 1;

  logic [NUM_STAGES-1:0]             valid_q, valid_d;
  logic [NUM_STAGES-1:0]             we_q, we_d;
  logic [NUM_STAGES-1:0]             ld_q, ld_d;
  logic [NUM_STAGES-1:0][REG_AW-1:0] rd_q, rd_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;

  logic [WIN-1:0] m1, m2;
  logic           hazard;
  logic           stall;
  logic           load_e0;

  // The W entry is excluded: the register file writes before it is read.
  genvar gi;
  generate
    for (gi = 0; gi < WIN; gi++) begin : g_match
      assign m1[gi] = d_valid_i && d_rs1_used_i && (d_rs1_addr_i != '0) &&
                      valid_q[gi] && we_q[gi] && (rd_q[gi] == d_rs1_addr_i);
      assign m2[gi] = d_valid_i && d_rs2_used_i && (d_rs2_addr_i != '0) &&
                      valid_q[gi] && we_q[gi] && (rd_q[gi] == d_rs2_addr_i);
    end
  endgenerate

`ifdef HAZARD_FWD_EN
  logic [2:0] sel1, sel2;

  always_comb begin
    sel1 = '0;
    sel2 = '0;
    // Descending scan so the youngest (lowest index) match wins.
    for (int k = WIN - 1; k >= 0; k--) begin
      if (m1[k]) sel1 = 3'(k + 1);
      if (m2[k]) sel2 = 3'(k + 1);
    end
    // A load still in X has no result yet: not forwardable, costs one bubble.
    if (m1[0] && ld_q[0]) sel1 = '0;
    if (m2[0] && ld_q[0]) sel2 = '0;
    hazard = ld_q[0] && (m1[0] || m2[0]);
  end

  assign fwd1_sel_o = stall ? 3'd0 : sel1;
  assign fwd2_sel_o = stall ? 3'd0 : sel2;
`else
  assign hazard     = (|m1) || (|m2);
  assign fwd1_sel_o = 3'd0;
  assign fwd2_sel_o = 3'd0;
`endif

  assign stall       = ext_stall_i || (hazard && !flush_i) || !rst_n_i;
  assign stall_o     = stall;
  assign incr_pc_o   = !stall;
  assign stall_cnt_o = cnt_q;

  always_comb begin
    load_e0 = d_valid_i && !stall && !flush_i;
    valid_d = {valid_q[NUM_STAGES-2:0], load_e0};
    we_d    = {we_q[NUM_STAGES-2:0], load_e0 && d_rd_we_i};
    ld_d    = {ld_q[NUM_STAGES-2:0], load_e0 && d_is_load_i};
    rd_d    = {rd_q[NUM_STAGES-2:0], (load_e0 ? d_rd_addr_i : {REG_AW{1'b0}})};
    cnt_d   = cnt_q;
    if (hazard && !flush_i && !(&cnt_q)) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valid_q <= '0;
      we_q    <= '0;
      ld_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else if (!ext_stall_i) begin
      valid_q <= valid_d;
      we_q    <= we_d;
      ld_q    <= ld_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  // The W entry only ages out; is_load is consumed solely by the forwarding path.
  logic unused_bits;
  assign unused_bits = ^{valid_q[WIN], we_q[WIN], ld_q, rd_q[WIN]};

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed vectors; the driver queues expected outputs, a negedge monitor compares.
module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        d_valid;
  logic [4:0]  rs1, rs2, rd;
  logic        used1, used2, we, is_load;
  logic        flush, ext_stall;
  logic        stall, incr_pc;
  logic [2:0]  fwd1, fwd2;
  logic [31:0] cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [39:0] exp_q[$];
  string       name_q[$];

  hazard_unit dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .d_valid_i    (d_valid),
    .d_rs1_addr_i (rs1),
    .d_rs2_addr_i (rs2),
    .d_rs1_used_i (used1),
    .d_rs2_used_i (used2),
    .d_rd_addr_i  (rd),
    .d_rd_we_i    (we),
    .d_is_load_i  (is_load),
    .flush_i      (flush),
    .ext_stall_i  (ext_stall),
    .stall_o      (stall),
    .incr_pc_o    (incr_pc),
    .fwd1_sel_o   (fwd1),
    .fwd2_sel_o   (fwd2),
    .stall_cnt_o  (cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [39:0] e;
      logic [39:0] a;
      string       n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {stall, incr_pc, fwd1, fwd2, cnt};
      n_vec++;
      if (a !== e)
        begin
          n_err++;
          $display("FAIL %s: got stall=%0b incr=%0b fwd1=%0d fwd2=%0d cnt=%0d, want stall=%0b incr=%0b fwd1=%0d fwd2=%0d cnt=%0d",
                   n, a[39], a[38], a[37:35], a[34:32], a[31:0], e[39], e[38], e[37:35], e[34:32], e[31:0]);
        end
      else
        $display("ok   %s: stall=%0b fwd1=%0d fwd2=%0d cnt=%0d", n, a[39], a[37:35], a[34:32], a[31:0]);
    end
  end

  task automatic ins(input logic v, input logic [4:0] a1, input logic [4:0] a2,
                     input logic [4:0] d, input logic ld);
    d_valid = v;
    rs1     = a1;
    rs2     = a2;
    rd      = d;
    used1   = v;
    used2   = v;
    we      = v;
    is_load = v & ld;
  endtask

  // Applies control inputs for one cycle and queues what the outputs must show during it.
  task automatic cyc(input string nm, input logic fl, input logic ex, input logic rn,
                     input logic es, input logic [2:0] e1, input logic [2:0] e2,
                     input logic [31:0] ec);
    flush     = fl;
    ext_stall = ex;
    rst_n     = rn;
    exp_q.push_back({es, ~es, e1, e2, ec});
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    ext_stall = 1'b0;
    ins(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    cyc("reset_state", 0, 0, 0, 1, 0, 0, 0);

`ifdef HAZARD_FWD_EN
    ins(1, 1, 2, 5, 0);   cyc("add_x5",          0, 0, 1, 0, 0, 0, 0);
    ins(1, 5, 1, 6, 0);   cyc("fwd_e0",          0, 0, 1, 0, 1, 0, 0);
    ins(1, 1, 2, 5, 0);   cyc("add_x5_again",    0, 0, 1, 0, 0, 0, 0);
    ins(1, 1, 2, 20, 0);  cyc("independent",     0, 0, 1, 0, 0, 0, 0);
    ins(1, 5, 1, 6, 0);   cyc("fwd_e1",          0, 0, 1, 0, 2, 0, 0);
    ins(1, 5, 6, 8, 0);   cyc("w_nomatch_youngest", 0, 0, 1, 0, 0, 1, 0);
    ins(1, 1, 0, 7, 1);   cyc("lw_x7",           0, 0, 1, 0, 0, 0, 0);
    ins(1, 7, 7, 8, 0);   cyc("load_use_stall",  0, 0, 1, 1, 0, 0, 0);
                          cyc("load_use_fwd",    0, 0, 1, 0, 2, 2, 1);
    ins(1, 8, 0, 9, 0);
    for (int i = 0; i < 3; i++) cyc("ext_stall_hold", 0, 1, 1, 1, 0, 0, 1);
                          cyc("ext_resume_fwd",  0, 0, 1, 0, 1, 0, 1);
    ins(1, 1, 0, 5, 1);   cyc("lw_x5",           0, 0, 1, 0, 0, 0, 1);
    ins(1, 5, 5, 10, 0);  cyc("flush_hazard",    1, 0, 1, 0, 0, 0, 1);
    ins(1, 10, 5, 11, 0); cyc("after_flush",     0, 0, 1, 0, 0, 2, 1);
    ins(1, 1, 0, 12, 1);  cyc("lw_x12",          0, 0, 1, 0, 0, 0, 1);
    ins(1, 12, 0, 13, 0); cyc("reset_mid_stall", 0, 0, 0, 1, 0, 0, 1);
                          cyc("after_reset",     0, 0, 1, 0, 0, 0, 0);
    ins(1, 1, 2, 0, 0);   cyc("write_x0",        0, 0, 1, 0, 0, 0, 0);
    ins(1, 0, 0, 14, 0);  cyc("read_x0",         0, 0, 1, 0, 0, 0, 0);
`else
    ins(1, 1, 2, 5, 0);   cyc("add_x5",          0, 0, 1, 0, 0, 0, 0);
    ins(1, 5, 5, 6, 0);   cyc("raw_stall_e0",    0, 0, 1, 1, 0, 0, 0);
                          cyc("raw_stall_e1",    0, 0, 1, 1, 0, 0, 1);
                          cyc("raw_clear_w",     0, 0, 1, 0, 0, 0, 2);
    ins(0, 0, 0, 0, 0);   cyc("nop_cnt2",        0, 0, 1, 0, 0, 0, 2);
    ins(1, 1, 2, 5, 0);   cyc("add_x5_b",        0, 0, 1, 0, 0, 0, 2);
    ins(1, 5, 0, 7, 0);   cyc("flush_hazard",    1, 0, 1, 0, 0, 0, 2);
    ins(1, 7, 7, 9, 0);   cyc("flushed_no_dep",  0, 0, 1, 0, 0, 0, 2);
    ins(1, 9, 0, 10, 0);
    for (int i = 0; i < 3; i++) cyc("ext_stall_hold", 0, 1, 1, 1, 0, 0, 2);
                          cyc("resume_e0",       0, 0, 1, 1, 0, 0, 2);
                          cyc("resume_e1",       0, 0, 1, 1, 0, 0, 3);
                          cyc("resume_clear",    0, 0, 1, 0, 0, 0, 4);
    ins(1, 10, 10, 11, 0); cyc("reset_mid_stall", 0, 0, 0, 1, 0, 0, 4);
                          cyc("after_reset",     0, 0, 1, 0, 0, 0, 0);
    ins(1, 0, 0, 0, 0);   cyc("write_x0",        0, 0, 1, 0, 0, 0, 0);
    ins(1, 0, 0, 12, 0);  cyc("read_x0",         0, 0, 1, 0, 0, 0, 0);
`endif

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d vectors unchecked, want 0", exp_q.size());
    end
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter NUM_STAGES, default 3, number of tracked in-flight stages after decode (entry 0 = X, last entry = W); legal range 2..6.
REQ-002 Parameter REG_AW, default 5, register address width.
REQ-003 Parameter CNT_W, default 32, stall performance counter width.
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n_i  input  1  reset, synchronous, active-low.
REQ-006 d_valid_i  input  1  decode stage holds a real instruction.
REQ-007 d_rs1_addr_i, d_rs2_addr_i  input  REG_AW each  decode source register addresses.
REQ-008 d_rs1_used_i, d_rs2_used_i  input  1 each  corresponding source is actually read.
REQ-009 d_rd_addr_i  input  REG_AW  decode destination register.
REQ-010 d_rd_we_i  input  1  decode instruction writes rd.
REQ-011 d_is_load_i  input  1  decode instruction is a load (result available after M).
REQ-012 flush_i  input  1  branch/jump resolved taken in X; kill decode instruction.
REQ-013 ext_stall_i  input  1  memory-side wait; freeze whole pipeline.
REQ-014 stall_o  output  1  hold F and D this cycle.
REQ-015 incr_pc_o  output  1  advance PC; always ~stall_o.
REQ-016 fwd1_sel_o, fwd2_sel_o  output  3 each  operand source for the instruction entering X: 0 = register file, k = result of shadow entry k-1.
REQ-017 stall_cnt_o  output  CNT_W  count of hazard-stall cycles.

Function
REQ-018 Shadow pipeline: NUM_STAGES entries, each {valid, rd, we, is_load}.
REQ-019 Advance (ext_stall_i=0): entry k+1 <= entry k; last entry's old value discarded.
REQ-020 Entry 0 load: decode fields when d_valid_i=1, stall_o=0, flush_i=0; otherwise bubble (valid=0).
REQ-021 ext_stall_i=1: all entries and the counter hold; stall_o=1; flush_i ignored that cycle.
REQ-022 Source match: used=1, addr!=0, entry valid=1, we=1, rd==addr.
REQ-023 Hazard window: entries 0..NUM_STAGES-2; last entry (W) never matches (register file is write-before-read).
REQ-024 Priority: flush_i (when ext_stall_i=0) forces stall_o=0 and suppresses hazard stall.
REQ-025 stall_o = ext_stall_i OR (hazard stall AND NOT flush_i) OR reset active; purely combinational from state and inputs.
REQ-026 stall_cnt_o increments by 1 on each edge where hazard stall was asserted and ext_stall_i=0; saturates at all-ones.
REQ-027 fwd*_sel_o = 0 whenever stall_o=1 or no forwardable match.
REQ-028 Operands with addr=0 never stall nor forward.

Reset
REQ-029 rst_n_i=0 sampled at an edge clears all entries to invalid and stall_cnt_o to 0; takes effect immediately, including mid-stall.
REQ-030 While rst_n_i=0: stall_o=1, incr_pc_o=0, fwd1_sel_o=fwd2_sel_o=0.
REQ-031 First edge with rst_n_i=1 behaves as empty pipeline: stall_o=0 unless ext_stall_i=1.

Configuration
REQ-032 Macro HAZARD_FWD_EN: when defined, a match in entry k of the window (REQ-023) forwards with sel=k+1 choosing the youngest (lowest k) match; stall only when the youngest match is entry 0 with is_load=1 (load-use, exactly one bubble).
REQ-033 When HAZARD_FWD_EN is undefined: any match in the window stalls; fwd*_sel_o are tied to 0.

Verification
REQ-034 Default params, no FWD: ADD x5 then ADD x6,x5,x5 back-to-back -> stall_o=1 for 2 cycles, third cycle stall_o=0, stall_cnt_o=2.
REQ-035 FWD: ADD x5 then ADD x6,x5,x1 -> stall_o=0, fwd1_sel_o=1, fwd2_sel_o=0; one later independent instruction between -> fwd1_sel_o=2.
REQ-036 FWD: LW x7 then ADD x8,x7,x7 -> stall_o=1 one cycle, then fwd1_sel_o=fwd2_sel_o=2, stall_cnt_o=1.
REQ-037 Hazard pending on x5 with flush_i=1 -> stall_o=0, entry 0 bubble, stall_cnt_o unchanged.
REQ-038 ext_stall_i=1 for 3 cycles mid-stream -> stall_o=1, shadow and stall_cnt_o frozen, resume with identical fwd values.
REQ-039 rst_n_i=0 for one edge during a hazard stall -> next cycle entries empty, stall_o=0, stall_cnt_o=0; source x0 with writer to x0 never stalls.
